// File: rtl/ecl_pkg.sv
// Shared definitions for the ECL-style OR/NOR bank: output mode encoding and
// the width of the per-channel glitch-filter counter.
package ecl_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      MODE_COMB   = 2'd0,
      MODE_REG    = 2'd1,
      MODE_HOLD   = 2'd2,
      MODE_FILTER = 2'd3
   } mode_e;

endpackage

// File: rtl/ecl_ornor_chan.sv
// One OR/NOR channel: holds the registered output bit and its FILTER-mode
// stability counter.
module ecl_ornor_chan
   import ecl_pkg::*;
#(
   parameter int unsigned FILTER = 2
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  i_or,
   input  mode_e i_mode,
   output logic  o_q
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER - 1);

   logic             r_q;
   logic [CNT_W-1:0] r_cnt;
   logic             w_q_next;
   logic [CNT_W-1:0] w_cnt_next;

   // Counter clears in every mode except FILTER, so entering FILTER starts from zero.
   always_comb begin
      w_q_next   = r_q;
      w_cnt_next = '0;
      case (i_mode)
         MODE_COMB, MODE_REG: w_q_next = i_or;
         MODE_HOLD: w_q_next = r_q;
         MODE_FILTER: begin
            if (i_or != r_q) begin
               if (r_cnt == CNT_MAX) begin
                  w_q_next = i_or;
               end else begin
                  w_cnt_next = r_cnt + CNT_W'(1);
               end
            end
         end
         default: w_q_next = r_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q   <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_q   <= w_q_next;
         r_cnt <= w_cnt_next;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/ecl_ornor_bank.sv
// Bank of independent OR/NOR channels sharing a common input, with selectable
// combinational, registered, held or glitch-filtered output.
module ecl_ornor_bank
   import ecl_pkg::*;
#(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned FILTER   = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] a,
   input  logic                common,
   input  logic [1:0]          mode,
   output logic [CHANNELS-1:0] q,
   output logic [CHANNELS-1:0] nq,
   output logic                changed
);

   mode_e               w_mode;
   logic [CHANNELS-1:0] w_or;
   logic [CHANNELS-1:0] w_q_r;
   logic [CHANNELS-1:0] r_q_prev;
   logic                r_changed;

   assign w_mode = mode_e'(mode);
   assign w_or   = a | {CHANNELS{common}};

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      ecl_ornor_chan #(
         .FILTER (FILTER)
      ) u_chan (
         .clk    (clk),
         .reset  (reset),
         .i_or   (w_or[i]),
         .i_mode (w_mode),
         .o_q    (w_q_r[i])
      );
   end

   // changed lags the q_r update by one cycle: compare q_r against its own past value.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q_prev  <= '0;
         r_changed <= 1'b0;
      end else begin
         r_q_prev  <= w_q_r;
         r_changed <= |(w_q_r ^ r_q_prev);
      end
   end

   assign q       = reset ? '0 : ((w_mode == MODE_COMB) ? w_or : w_q_r);
   assign nq      = ~q;
   assign changed = r_changed;

endmodule

// File: tb/tb_ecl_ornor_bank.sv
// Directed self-checking bench for ecl_ornor_bank (main instance CHANNELS=4,
// FILTER=2, plus 1- and 32-channel instances for the combinational sweep).
module tb_ecl_ornor_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  a;
   logic [0:0]  a1;
   logic [31:0] a32;
   logic        common;
   logic [1:0]  mode;
   logic [3:0]  q, nq;
   logic [0:0]  q1, nq1;
   logic [31:0] q32, nq32;
   logic        changed, changed1, changed32;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ecl_ornor_bank #(.CHANNELS(4), .FILTER(2)) dut (
      .clk(clk), .reset(reset), .a(a), .common(common), .mode(mode),
      .q(q), .nq(nq), .changed(changed)
   );

   ecl_ornor_bank #(.CHANNELS(1), .FILTER(2)) dut1 (
      .clk(clk), .reset(reset), .a(a1), .common(common), .mode(mode),
      .q(q1), .nq(nq1), .changed(changed1)
   );

   ecl_ornor_bank #(.CHANNELS(32), .FILTER(2)) dut32 (
      .clk(clk), .reset(reset), .a(a32), .common(common), .mode(mode),
      .q(q32), .nq(nq32), .changed(changed32)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; mode = 2'd0; a = 4'hF; a1 = 1'b1; a32 = '1; common = 1'b1;
      tick(); tick();
      checks++;
      if (q !== 4'h0 || nq !== 4'hF) begin
         errors++; $display("FAIL reset_comb_q q=%b nq=%b want 0000/1111", q, nq);
      end
      checks++;
      if (changed !== 1'b0) begin
         errors++; $display("FAIL reset_changed got %b want 0", changed);
      end
      checks++;
      if (q32 !== 32'h0 || nq32 !== 32'hFFFF_FFFF || q1 !== 1'b0) begin
         errors++; $display("FAIL reset_wide q32=%h nq32=%h q1=%b want 0/ffffffff/0", q32, nq32, q1);
      end
      mode = 2'd3; #1;
      checks++;
      if (q !== 4'h0 || nq !== 4'hF) begin
         errors++; $display("FAIL reset_filter_q q=%b nq=%b want 0000/1111", q, nq);
      end
      reset = 1'b0; mode = 2'd1; a = 4'h0; a1 = 1'b0; a32 = '0; common = 1'b0;
      tick();
      checks++;
      if (q !== 4'h0 || changed !== 1'b0) begin
         errors++; $display("FAIL post_reset q=%b changed=%b want 0000/0", q, changed);
      end
   endtask

   task automatic test_comb();
      mode = 2'd0; a = 4'b0101; common = 1'b0; #1;
      checks++;
      if (q !== 4'b0101 || nq !== 4'b1010) begin
         errors++; $display("FAIL comb_0101 q=%b nq=%b want 0101/1010", q, nq);
      end
      common = 1'b1; #1;
      checks++;
      if (q !== 4'b1111 || nq !== 4'b0000) begin
         errors++; $display("FAIL comb_common q=%b nq=%b want 1111/0000", q, nq);
      end
      tick();
      checks++;
      if (changed !== 1'b0) begin
         errors++; $display("FAIL comb_changed_early got %b want 0", changed);
      end
      tick();
      checks++;
      if (changed !== 1'b1) begin
         errors++; $display("FAIL comb_changed_pulse got %b want 1", changed);
      end
   endtask

   task automatic test_reg();
      mode = 2'd1; a = 4'h0; common = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (q !== 4'h0 || changed !== 1'b0) begin
         errors++; $display("FAIL reg_settle q=%b changed=%b want 0000/0", q, changed);
      end
      a = 4'b0011; #1;
      checks++;
      if (q !== 4'h0) begin
         errors++; $display("FAIL reg_lag q=%b want 0000", q);
      end
      tick();
      checks++;
      if (q !== 4'b0011 || nq !== 4'b1100 || changed !== 1'b0) begin
         errors++; $display("FAIL reg_n1 q=%b nq=%b changed=%b want 0011/1100/0", q, nq, changed);
      end
      tick();
      checks++;
      if (q !== 4'b0011 || changed !== 1'b1) begin
         errors++; $display("FAIL reg_n2 q=%b changed=%b want 0011/1", q, changed);
      end
      tick();
      checks++;
      if (changed !== 1'b0) begin
         errors++; $display("FAIL reg_n3 changed=%b want 0", changed);
      end
   endtask

   task automatic test_hold();
      mode = 2'd1; a = 4'b1010; common = 1'b0;
      tick(); tick(); tick();
      mode = 2'd2; common = 1'b1;
      for (int v = 0; v < 16; v++) begin
         a = 4'(v);
         tick();
         checks++;
         if (q !== 4'b1010 || nq !== 4'b0101 || changed !== 1'b0) begin
            errors++;
            $display("FAIL hold_v%0d q=%b nq=%b changed=%b want 1010/0101/0", v, q, nq, changed);
         end
      end
      mode = 2'd1; a = 4'b0011; common = 1'b0; #1;
      checks++;
      if (q !== 4'b1010) begin
         errors++; $display("FAIL hold_exit_lag q=%b want 1010", q);
      end
      tick();
      checks++;
      if (q !== 4'b0011) begin
         errors++; $display("FAIL hold_exit q=%b want 0011", q);
      end
      a = 4'h0;
      tick(); tick(); tick();
   endtask

   task automatic test_filter();
      mode = 2'd3; common = 1'b0; a = 4'b0001;
      tick();
      checks++;
      if (q !== 4'h0) begin
         errors++; $display("FAIL filt_short_q q=%b want 0000", q);
      end
      a = 4'h0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (q !== 4'h0 || changed !== 1'b0) begin
            errors++; $display("FAIL filt_short_k%0d q=%b changed=%b want 0000/0", k, q, changed);
         end
      end
      a = 4'b0001;
      tick();
      checks++;
      if (q !== 4'h0) begin
         errors++; $display("FAIL filt_long_c1 q=%b want 0000", q);
      end
      tick();
      checks++;
      if (q !== 4'b0001 || nq !== 4'b1110 || changed !== 1'b0) begin
         errors++; $display("FAIL filt_long_c2 q=%b nq=%b changed=%b want 0001/1110/0", q, nq, changed);
      end
      tick();
      checks++;
      if (q !== 4'b0001 || changed !== 1'b1) begin
         errors++; $display("FAIL filt_long_c3 q=%b changed=%b want 0001/1", q, changed);
      end
      tick();
      checks++;
      if (changed !== 1'b0) begin
         errors++; $display("FAIL filt_long_c4 changed=%b want 0", changed);
      end
      a = 4'h0;
      tick(); tick(); tick(); tick();
      checks++;
      if (q !== 4'h0 || changed !== 1'b0) begin
         errors++; $display("FAIL filt_fall q=%b changed=%b want 0000/0", q, changed);
      end
   endtask

   task automatic test_reset_filter();
      mode = 2'd3; common = 1'b0; a = 4'b0100;
      tick();
      reset = 1'b1;
      tick();
      checks++;
      if (q !== 4'h0 || nq !== 4'hF) begin
         errors++; $display("FAIL rstf_during q=%b nq=%b want 0000/1111", q, nq);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (q !== 4'h0) begin
         errors++; $display("FAIL rstf_discard q=%b want 0000", q);
      end
      tick();
      checks++;
      if (q !== 4'b0100 || nq !== 4'b1011) begin
         errors++; $display("FAIL rstf_rise q=%b nq=%b want 0100/1011", q, nq);
      end
   endtask

   task automatic test_sweep();
      logic [4:0]  v5;
      logic [3:0]  exp4;
      logic [31:0] exp32;
      mode = 2'd0;
      for (int v = 0; v < 32; v++) begin
         v5     = 5'(v);
         a      = v5[4:1];
         a1     = v5[1];
         a32    = {8{v5[4:1]}};
         common = v5[0];
         #1;
         exp4  = v5[4:1] | {4{v5[0]}};
         exp32 = {8{v5[4:1]}} | {32{v5[0]}};
         checks++;
         if (q !== exp4 || nq !== ~exp4) begin
            errors++; $display("FAIL sweep4_%0d q=%b nq=%b want %b/%b", v, q, nq, exp4, ~exp4);
         end
         checks++;
         if (q1 !== (v5[1] | v5[0]) || nq1 !== ~(v5[1] | v5[0])) begin
            errors++; $display("FAIL sweep1_%0d q=%b nq=%b want %b", v, q1, nq1, v5[1] | v5[0]);
         end
         checks++;
         if (q32 !== exp32 || nq32 !== ~exp32) begin
            errors++; $display("FAIL sweep32_%0d q=%h nq=%h want %h", v, q32, nq32, exp32);
         end
      end
   endtask

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_comb();
      test_reg();
      test_hold();
      test_filter();
      test_reset_filter();
      test_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ecl_ornor_bank.md
ECL_ORNOR_BANK -- requirements
Module: ecl_ornor_bank

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent OR/NOR channels (1..32).
REQ-002 Parameter FILTER, default 2, consecutive stable cycles required before a FILTER-mode output change (1..15).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 a  input  CHANNELS  per-channel data input.
REQ-006 common  input  1  shared input ORed into every channel.
REQ-007 mode  input  2  output mode: 0 COMB, 1 REG, 2 HOLD, 3 FILTER.
REQ-008 q  output  CHANNELS  OR output.
REQ-009 nq  output  CHANNELS  NOR output.
REQ-010 changed  output  1  one-cycle pulse after any bit of the internal output register changed.

Function
REQ-011 Per-channel OR value: or_v[i] = a[i] | common.
REQ-012 nq SHALL equal ~q on every bit at all times, in every mode, including reset.
REQ-013 Internal register q_r (CHANNELS bits) SHALL drive q in REG, HOLD, FILTER.
REQ-014 COMB: q = or_v combinationally (zero latency); q_r <= or_v each cycle so any mode switch is glitch-free.
REQ-015 REG: q_r <= or_v each cycle; q lags or_v by exactly 1 cycle.
REQ-016 HOLD: q_r unchanged; q constant regardless of a/common.
REQ-017 FILTER: per channel, 4-bit counter cnt[i]; cycles where or_v[i] != q_r[i] increment cnt[i]; cycles where they are equal clear cnt[i].
REQ-018 FILTER: on the edge where or_v[i] != q_r[i] and cnt[i] == FILTER-1, q_r[i] <= or_v[i] and cnt[i] <= 0; stable input change appears on q after exactly FILTER cycles.
REQ-019 FILTER: a pulse on or_v[i] shorter than FILTER cycles SHALL NOT reach q.
REQ-020 FILTER=1 SHALL make FILTER mode cycle-identical to REG.
REQ-021 All cnt[i] SHALL be cleared on every edge where mode != FILTER; entering FILTER starts from zero count.
REQ-022 Channels independent: counters and updates of one channel never affect another.
REQ-023 changed SHALL be registered: high for exactly one cycle after any edge on which q_r changed value; low otherwise.
REQ-024 COMB mode changes in q that also update q_r SHALL pulse changed one cycle later.
REQ-025 Mode change takes effect at the next edge for register behaviour; q source mux (comb vs q_r) follows mode immediately.

Reset
REQ-026 While reset is high at an edge: q_r <= 0, all cnt <= 0, changed <= 0.
REQ-027 While reset is asserted, q SHALL read all-zeros and nq all-ones in every mode, including COMB.
REQ-028 Reset mid-FILTER count SHALL discard the pending change; after release a full FILTER cycles of stability is again required.
REQ-029 First edge after reset deasserts SHALL operate per current mode normally.

Structure
REQ-030 Mode encoding SHALL be a typedef enum (COMB, REG, HOLD, FILTER) in shared package ecl_pkg alongside FILTER counter width constant.
REQ-031 Per-channel counter and q_r bit SHALL be one sub-module, ecl_ornor_chan, instantiated CHANNELS times by a generate loop.
REQ-032 Target size 120-400 lines RTL total.

Verification
REQ-033 COMB, CHANNELS=4: a=4'b0101, common=0 -> q=0101, nq=1010 same cycle; common=1 -> q=1111, nq=0000 same cycle.
REQ-034 REG: a steps 0000->0011 at cycle n -> q=0011 from cycle n+1, changed high only in cycle n+2.
REQ-035 FILTER, FILTER=2: a[0] high 1 cycle -> q[0] stays 0, changed never pulses; a[0] high 3 cycles -> q[0]=1 after 2 cycles, changed pulses once.
REQ-036 HOLD: from q=1010, drive all 16 a values and common=1 -> q stays 1010, nq 0101, changed stays 0; return to REG -> q follows after 1 cycle.
REQ-037 FILTER, a[2] rising held, reset asserted one cycle after rise -> q=0000/nq=1111 during reset; after release q[2] rises exactly FILTER cycles later.
REQ-038 Exhaustive 5-bit sweep {a,common} in COMB, all CHANNELS in {1,4,32} -> q == a|common and nq == ~q every step.
